// File: rtl/alu_out_drv.sv
// -----------------------------------------------------------------------------
// alu_out_drv
//   Write-back side of the ALU. Captures the ALU result into Y1 and its derived
//   flags into Y2. On request, drives Y1, Y2 or Y1-then-Y2 onto the shared
//   4-bit tri-state bus, holding each beat for HOLD cycles. The bus is
//   released (high-Z) whenever no beat is in progress.
//
// Parameters
//   HOLD        cycles each beat stays on the bus (1..4)
//
// Ports
//   clk         system clock, rising edge
//   grst_n      global reset, asynchronous, active-low
//   lrst        local reset, synchronous, active-high
//   ld          capture strobe for res/cout/ovf (honoured only when idle)
//   res         ALU result
//   cout        ALU carry out
//   ovf         ALU signed overflow
//   ws1         request: one Y1 (result) beat
//   ws2         request: one Y2 (flags) beat
//   wsa         request: Y1 beat followed by Y2 beat
//   bus         shared tri-state data bus
//   busy        high while any beat is in progress
//   valid       Y1/Y2 hold a captured result since the last reset
//   state_dbg_o current FSM state (0 idle, 1 drive Y1, 2 drive Y2)
//
// Handshake: a command is accepted only at a rising edge where busy is low;
// requests presented while busy (including the edge that returns to idle)
// are dropped, not queued. Priority among simultaneous requests is
// ws1 > ws2 > wsa.
// -----------------------------------------------------------------------------
module alu_out_drv #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       grst_n,
  input  logic       lrst,
  input  logic       ld,
  input  logic [3:0] res,
  input  logic       cout,
  input  logic       ovf,
  input  logic       ws1,
  input  logic       ws2,
  input  logic       wsa,
  inout  wire  [3:0] bus,
  output logic       busy,
  output logic       valid,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRV1 = 2'd1,
    DRV2 = 2'd2
  } state_e;

  localparam logic [1:0] LAST = 2'(HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       single_q, single_d;
  logic [3:0] y1_q, y1_d;
  logic [3:0] y2_q, y2_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  logic       drv_en;
  logic [3:0] drv_data;

  // State register
  always_ff @(posedge clk or negedge grst_n) begin
    if (!grst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      single_q <= 1'b0;
      y1_q     <= 4'd0;
      y2_q     <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = single_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        // Capture first so a same-edge request drives the new values.
        if (ld) begin
          y1_d    = res;
          y2_d    = {ovf, res[3], (res == 4'd0), cout};
          valid_d = 1'b1;
        end
        if (ws1) begin
          state_d  = DRV1;
          single_d = 1'b1;
        end else if (ws2) begin
          state_d = DRV2;
        end else if (wsa) begin
          state_d  = DRV1;
          single_d = 1'b0;
        end
      end
      DRV1: begin
        if (cnt_q == LAST) begin
          cnt_d   = 2'd0;
          state_d = single_q ? IDLE : DRV2;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DRV2: begin
        if (cnt_q == LAST) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    // Local reset aborts any beat and discards captured values.
    if (lrst) begin
      state_d  = IDLE;
      cnt_d    = 2'd0;
      single_d = 1'b0;
      y1_d     = 4'd0;
      y2_d     = 4'd0;
      valid_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != IDLE);

  // Output logic: drive enable comes straight from the state register so the
  // bus releases the instant grst_n clears it.
  always_comb begin
    drv_en   = 1'b0;
    drv_data = y1_q;
    unique case (state_q)
      DRV1: begin
        drv_en   = 1'b1;
        drv_data = y1_q;
      end
      DRV2: begin
        drv_en   = 1'b1;
        drv_data = y2_q;
      end
      default: begin
        drv_en   = 1'b0;
        drv_data = y1_q;
      end
    endcase
  end

  assign bus         = drv_en ? drv_data : 4'bzzzz;
  assign busy        = busy_q;
  assign valid       = valid_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_alu_out_drv.sv
// -----------------------------------------------------------------------------
// tb_alu_out_drv
//   Two instances (HOLD=1 and HOLD=2) share all inputs and each drive their
//   own bus, weakly pulled up so a released bus reads 4'hF. A reference model
//   turns every accepted command into a schedule of expected bus values, one
//   entry per cycle; the DUTs are compared against it every cycle, plus
//   directed checks with literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_out_drv;

  logic       clk;
  logic       grst_n;
  logic       lrst, ld, cout, ovf, ws1, ws2, wsa;
  logic [3:0] res;

  wire  [3:0] bus_a, bus_b;
  logic       busy_a, busy_b, valid_a, valid_b;
  logic [1:0] st_a, st_b;

  pullup (bus_a[0]);
  pullup (bus_a[1]);
  pullup (bus_a[2]);
  pullup (bus_a[3]);
  pullup (bus_b[0]);
  pullup (bus_b[1]);
  pullup (bus_b[2]);
  pullup (bus_b[3]);

  alu_out_drv #(.HOLD(1)) u_dut_a (
    .clk(clk), .grst_n(grst_n), .lrst(lrst), .ld(ld), .res(res),
    .cout(cout), .ovf(ovf), .ws1(ws1), .ws2(ws2), .wsa(wsa),
    .bus(bus_a), .busy(busy_a), .valid(valid_a), .state_dbg_o(st_a)
  );

  alu_out_drv #(.HOLD(2)) u_dut_b (
    .clk(clk), .grst_n(grst_n), .lrst(lrst), .ld(ld), .res(res),
    .cout(cout), .ovf(ovf), .ws1(ws1), .ws2(ws2), .wsa(wsa),
    .bus(bus_b), .busy(busy_b), .valid(valid_b), .state_dbg_o(st_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Index 0 models the HOLD=1 instance, index 1 the HOLD=2 instance.
  int         hold_of[2] = '{1, 2};
  logic [3:0] m_y1[2], m_y2[2], m_cur[2];
  logic       m_valid[2], m_active[2];
  logic [3:0] exp_q[2][$];

  task automatic model_clear(input int i);
    m_y1[i] = 4'd0;
    m_y2[i] = 4'd0;
    m_valid[i] = 1'b0;
    m_active[i] = 1'b0;
    m_cur[i] = 4'd0;
    exp_q[i].delete();
  endtask

  task automatic model_step(input int i);
    if (!m_active[i]) begin
      if (ld) begin
        m_y1[i] = res;
        m_y2[i] = {ovf, res[3], (res == 4'd0), cout};
        m_valid[i] = 1'b1;
      end
      if (ws1) begin
        for (int k = 0; k < hold_of[i]; k++) exp_q[i].push_back(m_y1[i]);
      end else if (ws2) begin
        for (int k = 0; k < hold_of[i]; k++) exp_q[i].push_back(m_y2[i]);
      end else if (wsa) begin
        for (int k = 0; k < hold_of[i]; k++) exp_q[i].push_back(m_y1[i]);
        for (int k = 0; k < hold_of[i]; k++) exp_q[i].push_back(m_y2[i]);
      end
    end
    if (exp_q[i].size() > 0) begin
      m_cur[i] = exp_q[i].pop_front();
      m_active[i] = 1'b1;
    end else begin
      m_active[i] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge grst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!grst_n || lrst) model_clear(i);
      else model_step(i);
    end
  end

  task automatic compare_all();
    check("bus_a",   bus_a, m_active[0] ? m_cur[0] : 4'hF);
    check("busy_a",  {3'b0, busy_a},  {3'b0, m_active[0]});
    check("valid_a", {3'b0, valid_a}, {3'b0, m_valid[0]});
    check("st_a",    {3'b0, (st_a != 2'd0)}, {3'b0, m_active[0]});
    check("bus_b",   bus_b, m_active[1] ? m_cur[1] : 4'hF);
    check("busy_b",  {3'b0, busy_b},  {3'b0, m_active[1]});
    check("valid_b", {3'b0, valid_b}, {3'b0, m_valid[1]});
    check("st_b",    {3'b0, (st_b != 2'd0)}, {3'b0, m_active[1]});
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge, are sampled at the next rising edge,
  // and outputs are compared at the following falling edge.
  task automatic step(input logic i_ld, input logic [3:0] i_res, input logic i_cout,
                      input logic i_ovf, input logic i_ws1, input logic i_ws2,
                      input logic i_wsa, input logic i_lrst);
    ld = i_ld; res = i_res; cout = i_cout; ovf = i_ovf;
    ws1 = i_ws1; ws2 = i_ws2; wsa = i_wsa; lrst = i_lrst;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    grst_n = 1'b0;
    lrst = 0; ld = 0; res = 0; cout = 0; ovf = 0; ws1 = 0; ws2 = 0; wsa = 0;

    // Reset then idle
    repeat (2) @(negedge clk);
    grst_n = 1'b1;
    idle(1);
    check("rst_bus", bus_a, 4'hF);
    check("rst_busy", {3'b0, busy_a}, 4'd0);
    check("rst_valid", {3'b0, valid_a}, 4'd0);

    // Capture and single result drive
    step(1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cap_valid", {3'b0, valid_a}, 4'd1);
    check("cap_idle_bus", bus_a, 4'hF);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ws1_bus", bus_a, 4'b1001);
    check("ws1_busy", {3'b0, busy_a}, 4'd1);
    idle(1);
    check("ws1_release", bus_a, 4'hF);
    check("ws1_busy_low", {3'b0, busy_a}, 4'd0);
    idle(2);

    // Flags
    step(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flags_zero", bus_a, 4'b1011);
    idle(3);
    step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("flags_neg", bus_a, 4'b0100);
    idle(3);

    // Burst on the HOLD=2 instance
    step(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("burst_c0", bus_b, 4'b0110);
    idle(1);
    check("burst_c1", bus_b, 4'b0110);
    idle(1);
    check("burst_c2", bus_b, 4'b1000);
    idle(1);
    check("burst_c3", bus_b, 4'b1000);
    check("burst_busy3", {3'b0, busy_b}, 4'd1);
    idle(1);
    check("burst_end", bus_b, 4'hF);
    check("burst_busy_end", {3'b0, busy_b}, 4'd0);
    idle(1);

    // Priority and busy rejection
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_y1", bus_a, 4'b0110);
    step(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("prio_single", bus_a, 4'hF);
    idle(2);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ld_busy_ignored", bus_a, 4'b0110);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ws2_busy_ignored", bus_a, 4'hF);
    idle(3);
    check("ws2_busy_ignored_b", bus_b, 4'hF);

    // Local reset mid-burst
    step(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("lrst_pre", bus_b, 4'b0101);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lrst_bus", bus_b, 4'hF);
    check("lrst_busy", {3'b0, busy_b}, 4'd0);
    check("lrst_valid", {3'b0, valid_b}, 4'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lrst_zero_drive", bus_b, 4'b0000);
    idle(3);

    // Asynchronous global reset in the middle of a Y1 beat
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("async_pre", bus_b, 4'b0000);
    #2 grst_n = 1'b0;
    #1;
    check("async_bus_a", bus_a, 4'hF);
    check("async_bus_b", bus_b, 4'hF);
    check("async_busy_b", {3'b0, busy_b}, 4'd0);
    @(negedge clk);
    grst_n = 1'b1;
    idle(2);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 11);
      step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           (r == 0 || r == 3), (r == 1 || r == 3), (r == 2 || r == 3),
           ($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
